// File: rtl/fft_engine.sv
// rtl/fft_engine.sv - iterative radix-2 DIT FFT/IFFT engine
// In-place over a register file, one butterfly per cycle, valid/ready streaming in and out.
module fft_engine #(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 16,
  parameter int TW_W     = 16,
  parameter int SCALE    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_W-1:0]    in_re,
  input  logic signed [DATA_W-1:0]    in_im,
  input  logic                        inv,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATA_W-1:0]    out_re,
  output logic signed [DATA_W-1:0]    out_im,
  output logic [$clog2(N_POINTS)-1:0] out_idx,
  output logic                        busy,
  output logic                        done,
  output logic                        sat
);
  localparam int L  = $clog2(N_POINTS);
  localparam int H  = N_POINTS / 2;
  localparam int SW = $clog2(L);
  localparam int PW = DATA_W + TW_W + 1;
  localparam int EW = DATA_W + 2;
  localparam real PI     = 3.14159265358979323846;
  localparam real TW_AMP = real'((2 ** (TW_W - 1)) - 1);
  localparam logic signed [PW-1:0] RND  = PW'(2 ** (TW_W - 2));
  localparam logic signed [EW-1:0] MAXV = EW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [EW-1:0] MINV = -MAXV - EW'(1);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  function automatic int round_real(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(0.5 - x);
  endfunction

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[i] = v[L-1-i];
    return r;
  endfunction

  function automatic logic oob(input logic signed [EW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [DATA_W-1:0] clamp(input logic signed [EW-1:0] v);
    if (v > MAXV) return MAXV[DATA_W-1:0];
    else if (v < MINV) return MINV[DATA_W-1:0];
    else return v[DATA_W-1:0];
  endfunction

  // Twiddle ROM holds cos/sin magnitudes; the sine sign is chosen by direction at use.
  logic signed [TW_W-1:0] tw_cos [H];
  logic signed [TW_W-1:0] tw_sin [H];
  for (genvar m = 0; m < H; m++) begin : g_tw
    localparam real ANG = 2.0 * PI * real'(m) / real'(N_POINTS);
    localparam int  C   = round_real($cos(ANG) * TW_AMP);
    localparam int  S   = round_real($sin(ANG) * TW_AMP);
    assign tw_cos[m] = TW_W'(C);
    assign tw_sin[m] = TW_W'(S);
  end

  logic signed [DATA_W-1:0] mem_re [N_POINTS];
  logic signed [DATA_W-1:0] mem_im [N_POINTS];

  state_t          state_q, state_d;
  logic [L-1:0]    k_q, k_d, idx_q, idx_d;
  logic [SW-1:0]   s_q, s_d;
  logic [L-2:0]    j_q, j_d;
  logic            inv_q, inv_d, sat_q, sat_d, done_q, done_d;
  logic            ld_we, bf_we;

  logic [L-1:0]             jx, span, top, bot;
  logic [L-2:0]             tw_idx;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [PW-1:0]     pr_full, pi_full;
  logic signed [EW-1:0]     p_re, p_im, sr, si, dr, di, s_re, s_im, d_re, d_im;
  logic                     clip;
  logic signed [DATA_W-1:0] top_re, top_im, bot_re, bot_im;

  always_comb begin
    jx      = {1'b0, j_q};
    span    = L'(1) << s_q;
    top     = (((jx >> s_q) << s_q) << 1) | (jx & (span - L'(1)));
    bot     = top | span;
    tw_idx  = (L-1)'((jx & (span - L'(1))) << (SW'(L - 1) - s_q));
    a_re    = mem_re[top];
    a_im    = mem_im[top];
    b_re    = mem_re[bot];
    b_im    = mem_im[bot];
    w_re    = tw_cos[tw_idx];
    w_im    = inv_q ? tw_sin[tw_idx] : -tw_sin[tw_idx];
    pr_full = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im) + RND;
    pi_full = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re) + RND;
    p_re    = EW'(pr_full >>> (TW_W - 1));
    p_im    = EW'(pi_full >>> (TW_W - 1));
    sr      = EW'(a_re) + p_re;
    si      = EW'(a_im) + p_im;
    dr      = EW'(a_re) - p_re;
    di      = EW'(a_im) - p_im;
    s_re    = (SCALE != 0) ? (sr >>> 1) : sr;
    s_im    = (SCALE != 0) ? (si >>> 1) : si;
    d_re    = (SCALE != 0) ? (dr >>> 1) : dr;
    d_im    = (SCALE != 0) ? (di >>> 1) : di;
    clip    = oob(s_re) || oob(s_im) || oob(d_re) || oob(d_im);
    top_re  = clamp(s_re);
    top_im  = clamp(s_im);
    bot_re  = clamp(d_re);
    bot_im  = clamp(d_im);
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    s_d       = s_q;
    j_d       = j_q;
    idx_d     = idx_q;
    inv_d     = inv_q;
    sat_d     = sat_q;
    done_d    = 1'b0;
    ld_we     = 1'b0;
    bf_we     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          ld_we = 1'b1;
          k_d   = k_q + L'(1);
          if (k_q == '0) begin
            inv_d = inv;
            sat_d = 1'b0;
          end
          if (&k_q) state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        bf_we = 1'b1;
        if (clip) sat_d = 1'b1;
        if (&j_q) begin
          j_d = '0;
          if (s_q == SW'(L - 1)) begin
            s_d     = '0;
            state_d = S_UNLOAD;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          j_d = j_q + (L-1)'(1);
        end
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          idx_d = idx_q + L'(1);
          if (&idx_q) begin
            done_d  = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      k_q     <= '0;
      s_q     <= '0;
      j_q     <= '0;
      idx_q   <= '0;
      inv_q   <= 1'b0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      j_q     <= j_d;
      idx_q   <= idx_d;
      inv_q   <= inv_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  // Sample store is deliberately not reset; every frame overwrites all entries before use.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_re[bitrev(k_q)] <= in_re;
      mem_im[bitrev(k_q)] <= in_im;
    end
    if (bf_we) begin
      mem_re[top] <= top_re;
      mem_im[top] <= top_im;
      mem_re[bot] <= bot_re;
      mem_im[bot] <= bot_im;
    end
  end

  assign out_re  = out_valid ? mem_re[idx_q] : '0;
  assign out_im  = out_valid ? mem_im[idx_q] : '0;
  assign out_idx = idx_q;
  assign done    = done_q;
  assign sat     = sat_q;

endmodule
